vector_instr_issuer: RTL

VECTOR_INSTR_ISSUER -- requirements
Module: vector_instr_issuer

---
 rtl/vector_instr_issuer_pkg.sv | 34 +++
 rtl/vector_instr_issuer_buffer.sv | 27 ++
 rtl/vector_instr_issuer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vector_instr_issuer_pkg.sv
// Shared vector-processor definitions: opcodes, instruction field layout and
// the issuer state encoding.
package vector_instr_issuer_pkg;

    localparam int INSTR_W = 13;
    localparam int OPC_HI  = 12;
    localparam int OPC_LO  = 11;
    localparam int REG_HI  = 10;
    localparam int REG_LO  = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 0;
    localparam int GAP_W   = 3;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_LOAD  = 2'b00;
    localparam opcode_t OP_STORE = 2'b01;
    localparam opcode_t OP_ADD   = 2'b10;
    localparam opcode_t OP_MUL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ALU-class instructions need recovery bubbles in the vector pipeline
    function automatic logic is_alu(input logic [INSTR_W-1:0] instr);
        opcode_t op;
        op = instr[OPC_HI:OPC_LO];
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/vector_instr_issuer_buffer.sv
// Instruction storage: synchronous write, combinational read, no reset so it
// maps onto distributed RAM.
module instr_buffer
    import vector_instr_issuer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = INSTR_W
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_instr_issuer.sv
// Buffers a program from the host, then replays it to the vector processor,
// inserting ALU_GAP bubble cycles after every ALU-class instruction.
module vector_instr_issuer
    import vector_instr_issuer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ALU_GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [INSTR_W-1:0]     load_instr,
    output logic                   load_ready,
    input  logic                   start,
    input  logic                   abort,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_e             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [GAP_W-1:0]   bubble_q, bubble_d;
    logic [INSTR_W-1:0] last_q, last_d;
    logic [INSTR_W-1:0] rd_data;
    logic               do_load;
    logic               do_issue;
    logic               issue_alu;
    logic               last_issue;
    logic               drained;

    // rd_ptr is one bit wider than the buffer index so "all issued" is
    // distinguishable from "nothing issued" when the buffer is full
    assign do_load    = load_valid && load_ready && !abort;
    assign do_issue   = (state_q == ST_RUN) && (bubble_q == '0) && !abort && !rst;
    assign issue_alu  = do_issue && is_alu(rd_data) && (ALU_GAP != 0);
    assign last_issue = (rd_ptr_q + CW'(1)) == count_q;
    assign drained    = (bubble_q == GAP_W'(1)) && (rd_ptr_q == count_q);

    instr_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_buffer (
        .clk_i   (clk),
        .we_i    (do_load),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_instr),
        .raddr_i (rd_ptr_q[PW-1:0]),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // trailing bubbles after the final ALU op must elapse first
                    if (do_issue) begin
                        if (last_issue && !issue_alu) begin
                            state_d = ST_DONE;
                        end
                    end else if (drained) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready  = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
        busy        = (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        instr_valid = do_issue;
        instruction = do_issue ? rd_data : last_q;
        count       = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bubble_d = bubble_q;
        last_d   = last_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            bubble_d = '0;
        end else begin
            if (do_load) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end
            if (do_issue) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
                last_d   = rd_data;
                bubble_d = issue_alu ? GAP_W'(ALU_GAP) : '0;
            end else if (bubble_q != '0) begin
                bubble_d = bubble_q - GAP_W'(1);
            end
            // rewind so the retained program can be replayed by the next start
            if (state_q == ST_DONE) begin
                rd_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
            last_q   <= last_d;
        end
    end

endmodule
